// File: rtl/cpu_pkg.sv
// Shared core definitions: register-file types plus the MEM/WB stage
// state encoding, funct3 codes and write-back register layout.
package cpu_pkg;

    localparam int RegBusWidth  = 32;
    localparam int RegAddrWidth = 5;

    typedef logic [RegAddrWidth-1:0] reg_addr_t;

    localparam logic [RegBusWidth-1:0] ZeroWord = '0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic                   valid;
        reg_addr_t              rd;
        logic                   rd_we;
        logic [RegBusWidth-1:0] data;
    } wb_reg_t;

    // Unsigned load sizes only exist on the load side; stores treat them as words.
    function automatic logic access_misaligned(input logic [2:0] funct3,
                                               input logic       is_load,
                                               input logic [1:0] addr_lo);
        logic is_byte;
        logic is_half;
        is_byte = (funct3 == F3_B) || (is_load && (funct3 == F3_BU));
        is_half = (funct3 == F3_H) || (is_load && (funct3 == F3_HU));
        if (is_byte) begin
            return 1'b0;
        end else if (is_half) begin
            return addr_lo[0];
        end
        return (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data-memory port: store strobes and lane
// replication, and load extraction with sign or zero extension.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]             funct3,
    input  logic [1:0]             addr_lo,
    input  logic [RegBusWidth-1:0] sdata,
    input  logic [RegBusWidth-1:0] rdata,
    output logic [3:0]             wstrb,
    output logic [RegBusWidth-1:0] wdata,
    output logic [RegBusWidth-1:0] ldata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // NOTE: every output of an always_comb gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        wstrb = 4'b1111;
        wdata = sdata;
        case (funct3)
            F3_B: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
            end
            F3_H: begin
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{sdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_byte = 8'(rdata >> {addr_lo, 3'b000});
    assign ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ldata = rdata;
        case (funct3)
            F3_B:    ldata = {{(RegBusWidth-8){ld_byte[7]}}, ld_byte};
            F3_BU:   ldata = {{(RegBusWidth-8){1'b0}}, ld_byte};
            F3_H:    ldata = {{(RegBusWidth-16){ld_half[15]}}, ld_half};
            F3_HU:   ldata = {{(RegBusWidth-16){1'b0}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: issues data-memory loads/stores over req/ready and drives the
// register-file write port. Optional macro MISALIGN_TRAP_EN rejects misaligned accesses.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int AddrWidth = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   ex_valid_i,
    input  reg_addr_t              ex_rd_i,
    input  logic                   ex_rd_we_i,
    input  logic [RegBusWidth-1:0] ex_alu_i,
    input  logic                   ex_mem_re_i,
    input  logic                   ex_mem_we_i,
    input  logic [2:0]             ex_funct3_i,
    input  logic [RegBusWidth-1:0] ex_sdata_i,
    output logic                   stall_o,
    output logic                   dm_req_o,
    output logic [3:0]             dm_wstrb_o,
    output logic [AddrWidth-1:0]   dm_addr_o,
    output logic [RegBusWidth-1:0] dm_wdata_o,
    input  logic [RegBusWidth-1:0] dm_rdata_i,
    input  logic                   dm_ready_i,
    output logic                   we_o,
    output reg_addr_t              waddr_o,
    output logic [RegBusWidth-1:0] wdata_o,
    output logic                   misalign_o
);

    mem_state_e             state;
    logic                   dm_req_q;
    logic [AddrWidth-1:0]   req_addr;
    logic [3:0]             req_wstrb;
    logic [RegBusWidth-1:0] req_wdata;
    logic [2:0]             req_funct3;
    logic [1:0]             req_lo;
    logic                   req_is_load;
    reg_addr_t              req_rd;
    logic                   req_rd_we;
    wb_reg_t                wb_q;

    logic                   in_access;
    logic                   is_mem;
    logic                   is_load;
    logic                   misaligned;
    logic                   start_access;

    logic [2:0]             al_funct3;
    logic [1:0]             al_lo;
    logic [3:0]             al_wstrb;
    logic [RegBusWidth-1:0] al_wdata;
    logic [RegBusWidth-1:0] al_ldata;

    assign in_access = (state == ACCESS);
    assign is_mem    = ex_mem_re_i | ex_mem_we_i;
    // Load wins when both load and store are flagged.
    assign is_load   = ex_mem_re_i;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;

    assign misaligned = access_misaligned(ex_funct3_i, is_load, ex_alu_i[1:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= !in_access && ex_valid_i && is_mem && misaligned;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misaligned = 1'b0;
    assign misalign_o = 1'b0;
`endif

    assign start_access = !in_access && ex_valid_i && is_mem && !misaligned;
    assign stall_o      = in_access ? !dm_ready_i : start_access;

    // One aligner serves both directions: EX fields while idle (store lanes),
    // the held request fields while the access is outstanding (load extract).
    assign al_funct3 = in_access ? req_funct3 : ex_funct3_i;
    assign al_lo     = in_access ? req_lo     : ex_alu_i[1:0];

    lsu_align u_align (
        .funct3  (al_funct3),
        .addr_lo (al_lo),
        .sdata   (ex_sdata_i),
        .rdata   (dm_rdata_i),
        .wstrb   (al_wstrb),
        .wdata   (al_wdata),
        .ldata   (al_ldata)
    );

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            dm_req_q    <= 1'b0;
            req_addr    <= '0;
            req_wstrb   <= '0;
            req_wdata   <= ZeroWord;
            req_funct3  <= '0;
            req_lo      <= '0;
            req_is_load <= 1'b0;
            req_rd      <= '0;
            req_rd_we   <= 1'b0;
            wb_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wb_q <= '0;
                    if (ex_valid_i && !is_mem) begin
                        wb_q.valid <= 1'b1;
                        wb_q.rd    <= ex_rd_i;
                        wb_q.rd_we <= ex_rd_we_i;
                        wb_q.data  <= ex_alu_i;
                    end else if (start_access) begin
                        state       <= ACCESS;
                        dm_req_q    <= 1'b1;
                        req_addr    <= AddrWidth'({ex_alu_i[31:2], 2'b00});
                        req_wstrb   <= is_load ? 4'b0000 : al_wstrb;
                        req_wdata   <= al_wdata;
                        req_funct3  <= ex_funct3_i;
                        req_lo      <= ex_alu_i[1:0];
                        req_is_load <= is_load;
                        req_rd      <= ex_rd_i;
                        req_rd_we   <= ex_rd_we_i;
                    end
                end
                ACCESS: begin
                    wb_q <= '0;
                    if (dm_ready_i) begin
                        state    <= IDLE;
                        dm_req_q <= 1'b0;
                        if (req_is_load) begin
                            wb_q.valid <= 1'b1;
                            wb_q.rd    <= req_rd;
                            wb_q.rd_we <= req_rd_we;
                            wb_q.data  <= al_ldata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dm_req_o   = dm_req_q;
    assign dm_addr_o  = req_addr;
    assign dm_wstrb_o = req_wstrb;
    assign dm_wdata_o = req_wdata;

    // x0 is hard-wired to zero, so writes to it are suppressed at the port.
    assign we_o    = wb_q.valid && wb_q.rd_we && (wb_q.rd != '0);
    assign waddr_o = wb_q.rd;
    assign wdata_o = wb_q.data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, reset and idle
// corner sequences, and randomized operations against a behavioural model.
module tb_mem_wb_stage;
    import cpu_pkg::*;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   ex_valid_i;
    reg_addr_t              ex_rd_i;
    logic                   ex_rd_we_i;
    logic [31:0]            ex_alu_i;
    logic                   ex_mem_re_i;
    logic                   ex_mem_we_i;
    logic [2:0]             ex_funct3_i;
    logic [31:0]            ex_sdata_i;
    logic                   stall_o;
    logic                   dm_req_o;
    logic [3:0]             dm_wstrb_o;
    logic [31:0]            dm_addr_o;
    logic [31:0]            dm_wdata_o;
    logic [31:0]            dm_rdata_i;
    logic                   dm_ready_i;
    logic                   we_o;
    reg_addr_t              waddr_o;
    logic [31:0]            wdata_o;
    logic                   misalign_o;

    mem_wb_stage #(.AddrWidth(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ex_valid_i  (ex_valid_i),
        .ex_rd_i     (ex_rd_i),
        .ex_rd_we_i  (ex_rd_we_i),
        .ex_alu_i    (ex_alu_i),
        .ex_mem_re_i (ex_mem_re_i),
        .ex_mem_we_i (ex_mem_we_i),
        .ex_funct3_i (ex_funct3_i),
        .ex_sdata_i  (ex_sdata_i),
        .stall_o     (stall_o),
        .dm_req_o    (dm_req_o),
        .dm_wstrb_o  (dm_wstrb_o),
        .dm_addr_o   (dm_addr_o),
        .dm_wdata_o  (dm_wdata_o),
        .dm_rdata_i  (dm_rdata_i),
        .dm_ready_i  (dm_ready_i),
        .we_o        (we_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .misalign_o  (misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic        re;
        logic        we;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          lat;
    } op_t;

    typedef struct {
        int          stall;
        logic        req;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] dwdata;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mis;
        logic        unstable;
    } res_t;

    typedef struct {
        op_t  op;
        res_t exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic res_t res_zero();
        res_t r;
        r.stall = 0; r.req = 0; r.addr = 0; r.wstrb = 0; r.dwdata = 0;
        r.we = 0; r.waddr = 0; r.wdata = 0; r.mis = 0; r.unstable = 0;
        return r;
    endfunction

    function automatic op_t mk_op(logic [2:0] f3, logic re, logic we, logic [4:0] rd,
                                  logic rd_we, logic [31:0] alu, logic [31:0] sdata,
                                  logic [31:0] rdata, int lat);
        op_t o;
        o.f3 = f3; o.re = re; o.we = we; o.rd = rd; o.rd_we = rd_we;
        o.alu = alu; o.sdata = sdata; o.rdata = rdata; o.lat = lat;
        return o;
    endfunction

    function automatic res_t mk_exp(int stall, logic req, logic [31:0] addr, logic [3:0] wstrb,
                                    logic [31:0] dwdata, logic we, logic [4:0] waddr,
                                    logic [31:0] wdata, logic mis);
        res_t e = res_zero();
        e.stall = stall; e.req = req; e.addr = addr; e.wstrb = wstrb; e.dwdata = dwdata;
        e.we = we; e.waddr = waddr; e.wdata = wdata; e.mis = mis;
        return e;
    endfunction

    // Reference model: derives the observable result of one instruction from
    // access size, byte offset and plain shift/mask arithmetic.
    function automatic res_t model(op_t op);
        res_t        e = res_zero();
        int          idx = int'(op.alu % 4);
        int          size;
        logic [31:0] b;
        logic [31:0] h;
        if (!(op.re || op.we)) begin
            e.we = op.rd_we && (op.rd != 0);
            e.waddr = op.rd;
            e.wdata = op.alu;
            return e;
        end
        if (op.re) size = (op.f3 == 0 || op.f3 == 4) ? 1 : (op.f3 == 1 || op.f3 == 5) ? 2 : 4;
        else       size = (op.f3 == 0) ? 1 : (op.f3 == 1) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
        if (idx % size != 0) begin
            e.mis = 1;
            return e;
        end
`endif
        e.stall = op.lat;
        e.req = 1;
        e.addr = op.alu - 32'(idx);
        if (op.re) begin
            b = (op.rdata >> (8 * idx)) & 32'hFF;
            h = (op.rdata >> (16 * (idx / 2))) & 32'hFFFF;
            case (op.f3)
                3'd0:    e.wdata = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
                3'd4:    e.wdata = b;
                3'd1:    e.wdata = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
                3'd5:    e.wdata = h;
                default: e.wdata = op.rdata;
            endcase
            e.we = op.rd_we && (op.rd != 0);
            e.waddr = op.rd;
        end else if (size == 1) begin
            e.wstrb = 4'(1 << idx);
            e.dwdata = (op.sdata & 32'hFF) * 32'h0101_0101;
        end else if (size == 2) begin
            e.wstrb = 4'(3 << ((idx / 2) * 2));
            e.dwdata = (op.sdata & 32'hFFFF) * 32'h0001_0001;
        end else begin
            e.wstrb = 4'hF;
            e.dwdata = op.sdata;
        end
        return e;
    endfunction

    task automatic sample_wb(inout res_t r);
        r.we = we_o;
        r.waddr = waddr_o;
        r.wdata = wdata_o;
    endtask

    // Presents one instruction, plays the memory with the op's latency and
    // collects what the stage did up to and including its write-back cycle.
    task automatic do_op(input op_t op, output res_t r);
        int   guard = 0;
        int   reqc = 0;
        logic done = 0;
        r = res_zero();
        @(negedge clk);
        ex_valid_i = 1; ex_funct3_i = op.f3; ex_mem_re_i = op.re; ex_mem_we_i = op.we;
        ex_rd_i = op.rd; ex_rd_we_i = op.rd_we; ex_alu_i = op.alu; ex_sdata_i = op.sdata;
        dm_ready_i = 0; dm_rdata_i = $urandom;
        #1;
        if (stall_o) r.stall++;
        while (!done && guard < 50) begin
            @(negedge clk);
            guard++;
            if (misalign_o) r.mis = 1;
            if (dm_req_o) begin
                if (!r.req) begin
                    r.req = 1; r.addr = dm_addr_o; r.wstrb = dm_wstrb_o; r.dwdata = dm_wdata_o;
                end else if (dm_addr_o !== r.addr || dm_wstrb_o !== r.wstrb || dm_wdata_o !== r.dwdata) begin
                    r.unstable = 1;
                end
                reqc++;
                if (reqc >= op.lat) begin
                    dm_ready_i = 1;
                    dm_rdata_i = op.rdata;
                end
                #1;
                if (stall_o) r.stall++;
                if (reqc >= op.lat) begin
                    @(negedge clk);
                    sample_wb(r);
                    done = 1;
                end
            end else begin
                sample_wb(r);
                done = 1;
            end
        end
        ex_valid_i = 0; dm_ready_i = 0;
        if (!done) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic compare(input string tag, input op_t op, input res_t r, input res_t e);
        check({tag, " stall_cycles"}, r.stall, e.stall);
        check({tag, " dm_req"}, r.req, e.req);
        if (e.req) begin
            check({tag, " dm_addr"}, r.addr, e.addr);
            check({tag, " dm_wstrb"}, r.wstrb, e.wstrb);
            check({tag, " req_stable"}, r.unstable, 0);
            if (op.we && !op.re) check({tag, " dm_wdata"}, r.dwdata, e.dwdata);
        end
        check({tag, " we"}, r.we, e.we);
        if (e.we) begin
            check({tag, " waddr"}, r.waddr, e.waddr);
            check({tag, " wdata"}, r.wdata, e.wdata);
        end
        check({tag, " misalign"}, r.mis, e.mis);
    endtask

    initial begin
        vec_t vecs[12];
        res_t r;
        op_t  op;
        int   kind;

        vecs[0]  = '{mk_op(3'd0, 0, 0, 5'd5, 1, 32'h1234, 0, 0, 1),
                     mk_exp(0, 0, 0, 0, 0, 1, 5'd5, 32'h1234, 0)};
        vecs[1]  = '{mk_op(3'd0, 1, 0, 5'd7, 1, 32'h103, 0, 32'h80FF_FFFF, 3),
                     mk_exp(3, 1, 32'h100, 4'h0, 0, 1, 5'd7, 32'hFFFF_FF80, 0)};
        vecs[2]  = '{mk_op(3'd4, 1, 0, 5'd7, 1, 32'h103, 0, 32'h80FF_FFFF, 3),
                     mk_exp(3, 1, 32'h100, 4'h0, 0, 1, 5'd7, 32'h0000_0080, 0)};
        vecs[3]  = '{mk_op(3'd1, 0, 1, 5'd3, 0, 32'h202, 32'hAAAA_BEEF, 0, 1),
                     mk_exp(1, 1, 32'h200, 4'hC, 32'hBEEF_BEEF, 0, 0, 0, 0)};
        vecs[4]  = '{mk_op(3'd2, 1, 0, 5'd0, 1, 32'h40, 0, 32'h55AA_55AA, 2),
                     mk_exp(2, 1, 32'h40, 4'h0, 0, 0, 0, 0, 0)};
`ifdef MISALIGN_TRAP_EN
        vecs[5]  = '{mk_op(3'd2, 1, 0, 5'd9, 1, 32'h102, 0, 32'h1122_3344, 2),
                     mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 1)};
`else
        vecs[5]  = '{mk_op(3'd2, 1, 0, 5'd9, 1, 32'h102, 0, 32'h1122_3344, 2),
                     mk_exp(2, 1, 32'h100, 4'h0, 0, 1, 5'd9, 32'h1122_3344, 0)};
`endif
        vecs[6]  = '{mk_op(3'd1, 1, 0, 5'd10, 1, 32'h106, 0, 32'h8001_1234, 1),
                     mk_exp(1, 1, 32'h104, 4'h0, 0, 1, 5'd10, 32'hFFFF_8001, 0)};
        vecs[7]  = '{mk_op(3'd5, 1, 0, 5'd11, 1, 32'h104, 0, 32'h8001_F234, 2),
                     mk_exp(2, 1, 32'h104, 4'h0, 0, 1, 5'd11, 32'h0000_F234, 0)};
        vecs[8]  = '{mk_op(3'd0, 0, 1, 5'd1, 1, 32'h301, 32'h1234_5678, 0, 1),
                     mk_exp(1, 1, 32'h300, 4'h2, 32'h7878_7878, 0, 0, 0, 0)};
        vecs[9]  = '{mk_op(3'd2, 0, 1, 5'd2, 1, 32'h10, 32'hDEAD_BEEF, 0, 4),
                     mk_exp(4, 1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 0)};
        vecs[10] = '{mk_op(3'd0, 1, 1, 5'd12, 1, 32'h2, 32'hFFFF_FFFF, 32'h00AB_0000, 1),
                     mk_exp(1, 1, 32'h0, 4'h0, 0, 1, 5'd12, 32'hFFFF_FFAB, 0)};
        vecs[11] = '{mk_op(3'd0, 0, 0, 5'd8, 0, 32'd77, 0, 0, 1),
                     mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0)};

        rstn = 0; ex_valid_i = 0; ex_rd_i = 0; ex_rd_we_i = 0; ex_alu_i = 0;
        ex_mem_re_i = 0; ex_mem_we_i = 0; ex_funct3_i = 0; ex_sdata_i = 0;
        dm_rdata_i = 0; dm_ready_i = 0;
        repeat (3) @(negedge clk);
        check("reset dm_req", dm_req_o, 0);
        check("reset stall", stall_o, 0);
        check("reset we", we_o, 0);
        check("reset waddr", waddr_o, 0);
        check("reset wdata", wdata_o, 0);
        check("reset wstrb", dm_wstrb_o, 0);
        check("reset addr", dm_addr_o, 0);
        check("reset misalign", misalign_o, 0);
        rstn = 1;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, r);
            compare($sformatf("vec%0d", i), vecs[i].op, r, vecs[i].exp);
        end

        // dm_ready_i outside an access must have no effect.
        @(negedge clk);
        dm_ready_i = 1; dm_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        check("idle_ready dm_req", dm_req_o, 0);
        check("idle_ready we", we_o, 0);
        check("idle_ready stall", stall_o, 0);
        dm_ready_i = 0;

        // Reset while an access is outstanding abandons it immediately.
        @(negedge clk);
        ex_valid_i = 1; ex_mem_re_i = 1; ex_mem_we_i = 0; ex_funct3_i = 3'd2;
        ex_alu_i = 32'h80; ex_rd_i = 5'd4; ex_rd_we_i = 1; dm_ready_i = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid req_before", dm_req_o, 1);
        check("rst_mid stall_before", stall_o, 1);
        #1 rstn = 0; ex_valid_i = 0;
        #1;
        check("rst_mid req", dm_req_o, 0);
        check("rst_mid stall", stall_o, 0);
        check("rst_mid we", we_o, 0);
        @(negedge clk);
        rstn = 1;
        op = mk_op(3'd0, 0, 0, 5'd6, 1, 32'hCAFE, 0, 0, 1);
        do_op(op, r);
        compare("rst_mid alu", op, r, model(op));

        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 3));
            op = mk_op(3'($urandom_range(0, 7)), kind == 1 || kind == 3, kind == 2 || kind == 3,
                       5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                       $urandom, $urandom, int'($urandom_range(1, 4)));
            do_op(op, r);
            compare($sformatf("rnd%0d", i), op, r, model(op));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage of the 5-stage core. It consumes the EX/MEM pipeline register and performs data-memory loads and stores over a req/ready handshake. It aligns and extends load data, registers the result, and drives the register-file write port (`we`/`waddr`/`wdata`). While a memory access is outstanding it stalls the upstream pipeline.

## Interface
Parameters:
- `AddrWidth`, default 32: data-memory byte-address width.
- `RegBusWidth`, default 32, from `cpu_pkg`: data word width.

Ports:
- `clk`, input, 1: clock.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `ex_valid_i`, input, 1: EX/MEM register holds a valid instruction.
- `ex_rd_i`, input, `reg_addr_t`: destination register.
- `ex_rd_we_i`, input, 1: instruction writes `rd`.
- `ex_alu_i`, input, 32: ALU result, also the memory address.
- `ex_mem_re_i`, input, 1: instruction is a load.
- `ex_mem_we_i`, input, 1: instruction is a store.
- `ex_funct3_i`, input, 3: access size/sign.
- `ex_sdata_i`, input, 32: store data (rs2).
- `stall_o`, output, 1: upstream must hold the EX/MEM register.
- `dm_req_o`, output, 1: memory request valid.
- `dm_wstrb_o`, output, 4: byte write strobes; 0 for a load.
- `dm_addr_o`, output, `AddrWidth`: word-aligned address, low two bits = 0.
- `dm_wdata_o`, output, 32: lane-replicated store data.
- `dm_rdata_i`, input, 32: read data, valid when `dm_ready_i`=1.
- `dm_ready_i`, input, 1: request completes this cycle.
- `we_o`, output, 1: register-file write enable.
- `waddr_o`, output, `reg_addr_t`: register-file write address.
- `wdata_o`, output, 32: register-file write data.
- `misalign_o`, output, 1: misaligned-access pulse (macro only).

## Operation
- FSM states `IDLE` and `ACCESS`.
- `IDLE`, `ex_valid_i`=1, no memory op:
  - `stall_o`=0.
  - WB register captures `rd`, `rd_we`, `ex_alu_i`.
- `IDLE`, `ex_valid_i`=1, load or store:
  - `stall_o`=1 combinationally.
  - Request registers latch address, strobes and data.
  - Next state `ACCESS`.
  - WB register captures `we`=0 (bubble).
- `ACCESS`:
  - `dm_req_o`=1 and request fields are held stable.
  - `stall_o`=~`dm_ready_i`.
  - On `dm_ready_i`=1, a load writes the aligned data into the WB register; a store writes `we`=0. Next state `IDLE`.
- `ex_valid_i`=0 in `IDLE`: WB register captures `we`=0.
- Outputs come straight from the WB register: `we_o`=`wb_valid & rd_we & (rd!=0)`.
- Store strobes:
  - SB (000): `0001<<addr[1:0]`, byte replicated ×4.
  - SH (001): `0011<<{addr[1],0}`, half replicated ×2.
  - SW and any other funct3: `1111`.
- Load extraction:
  - LB (000) and LBU (100): byte `addr[1:0]`.
  - LH (001) and LHU (101): half `addr[1]`.
  - LW (010) and any other funct3: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Load and store both set → treated as a load.

## Timing
- Reset value of every output and register is 0; state is `IDLE`. Reset mid-`ACCESS` drops `dm_req_o` immediately and abandons the access.
- Non-memory instruction accepted at cycle N → `we_o` at N+1.
- Memory op presented at N:
  - `dm_req_o` from N+1.
  - `dm_ready_i` first sampled high at cycle M ≥ N+1.
  - Load write-back at M+1.
  - `stall_o` is high N..M-1 and low at M, so upstream advances at the end of M.
- `dm_ready_i` while not in `ACCESS` is ignored.
- Back-to-back loads: the second request is issued at M+2 at the earliest, since `IDLE` re-evaluates at M+1.
- Load-use forwarding relies on the register file's same-cycle write bypass.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A halfword access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, does not enter `ACCESS`.
  - `misalign_o` pulses for one cycle at N+1.
  - The WB register writes `we`=0 and `stall_o` stays 0.
- `MISALIGN_TRAP_EN` undefined:
  - `misalign_o` is tied to 0.
  - Address low bits are ignored for lane selection beyond the rules above, i.e. the access proceeds using the truncated aligned address.

## Structure
- `cpu_pkg` additions:
  - `mem_state_e` for `IDLE`/`ACCESS`.
  - funct3 localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - `wb_reg_t` struct holding `valid`, `rd`, `rd_we`, `data`.
- Reuses `reg_addr_t`, `RegBusWidth`, `ZeroWord`.
- One combinational sub-module `lsu_align`: store strobe and lane replication plus load extract and extend, shared by both directions.

## Test plan
- ALU op, rd=5, alu=0x1234 at N → `we_o`=1, `waddr_o`=5, `wdata_o`=0x1234 at N+1; `stall_o` never asserted.
- LB, addr 0x103, `dm_rdata_i`=0x80FF_FFFF, ready 3 cycles after request → `stall_o` high for 3 cycles, then `wdata_o`=0xFFFF_FF80. The same access as LBU → `wdata_o`=0x80.
- SH, addr 0x202, `ex_sdata_i`=0xAAAA_BEEF → `dm_wstrb_o`=1100, `dm_wdata_o`=0xBEEF_BEEF, `dm_addr_o`=0x200, `we_o`=0.
- Load to rd=0 → memory access occurs, `we_o` stays 0.
- `rstn` low during `ACCESS` → `dm_req_o` and `stall_o` go to 0 immediately; after release, an ALU op completes normally.
- LW at 0x102:
  - With `MISALIGN_TRAP_EN`: `misalign_o` pulses, `dm_req_o` stays 0, no write.
  - Without it: `dm_addr_o`=0x100, load completes.
